wb_master_bridge: RTL
=====================

// Module: wb_master_bridge
// PURPOSE
// - Upstream stage of the Wishbone block RAM: converts a core-side valid/ready request and response
//   port into single Wishbone classic cycles (one outstanding transfer, no pipelining).
// - Latches each request, holds cyc/stb/adr/dat/sel/we stable until slave ack/err, and returns
//   rdata/err on a valid/ready response port. Used by fetch and LSU paths to reach WB memories.
// PARAMETERS
// - ADDR_WIDTH      20   byte-address width, passed to wb_adr_o unmodified (slave does word padding)
// - DATA_WIDTH      32   data width; must be a multiple of 8; SEL_W = DATA_WIDTH/8
// - TIMEOUT_CYCLES  255  bus-wait limit in cycles, >=2; used only when WB_BRIDGE_TIMEOUT_EN is defined
// PORTS
// - clk_i          in   1           clock, all logic on rising edge
// - rst_ni         in   1           synchronous active-low reset
// - req_valid_i    in   1           request present
// - req_ready_o    out  1           bridge can accept a request (high only in ST_IDLE)
// - req_addr_i     in   ADDR_WIDTH  byte address
// - req_we_i       in   1           1 = write, 0 = read
// - req_be_i       in   SEL_W       byte enables, mapped to wb_sel_o
// - req_wdata_i    in   DATA_WIDTH  write data
// - rsp_valid_o    out  1           response present (high only in ST_RESP)
// - rsp_ready_i    in   1           consumer takes response
// - rsp_rdata_o    out  DATA_WIDTH  read data; 0 for writes and errored transfers
// - rsp_err_o      out  1           transfer terminated by wb_err_i or timeout
// - wb_cyc_o, wb_stb_o  out 1       Wishbone cycle/strobe (identical)
// - wb_we_o        out  1           Wishbone write enable
// - wb_adr_o       out  ADDR_WIDTH  Wishbone address
// - wb_sel_o       out  SEL_W       Wishbone byte select
// - wb_dat_o       out  DATA_WIDTH  Wishbone write data
// - wb_dat_i       in   DATA_WIDTH  Wishbone read data, sampled on ack
// - wb_ack_i, wb_err_i  in 1        Wishbone termination
// BEHAVIOUR
// - Reset (rst_ni=0 at edge): state ST_IDLE; cyc/stb/we=0; adr/sel/dat regs=0; rsp_rdata_o=0;
//   rsp_err_o=0; timeout counter=0. Reset mid-transfer drops cyc next edge; response is discarded.
// - FSM ST_IDLE -> ST_BUS -> ST_RESP -> ST_IDLE; all outputs decoded from registers only.
// - ST_IDLE: req_ready_o=1. req_valid_i=1 at edge: latch addr/we/be/wdata, go ST_BUS.
// - ST_BUS: wb_cyc_o=wb_stb_o=1, other wb_* outputs from latched regs, stable for whole cycle.
//   wb_err_i=1: rdata<=0, err<=1, go ST_RESP. Else wb_ack_i=1: rdata<=(we ? 0 : wb_dat_i),
//   err<=0, go ST_RESP. Both high: err wins. cyc/stb low the cycle after termination.
// - ST_RESP: rsp_valid_o=1, rdata/err held stable. rsp_ready_i=1 at edge: go ST_IDLE.
// - Latency: accept edge k -> cyc high from k+1; ack at edge k+1+N -> rsp_valid high from k+2+N.
//   Minimum turnaround request->next accept = 3 + N cycles (no back-to-back overlap).
// - wb_ack_i/wb_err_i outside ST_BUS are ignored (no state or data change).
// - be=0 still issues a full bus cycle; address alignment not checked (slave ignores low bits).
// CONFIGURATION
// - WB_BRIDGE_TIMEOUT_EN defined: counter clears on entry to ST_BUS, increments each ST_BUS
//   cycle without ack/err; at count TIMEOUT_CYCLES-1 with no termination, go ST_RESP with err=1,
//   rdata=0, cyc dropped next cycle. Ack/err in that same cycle wins over timeout. Late ack ignored.
// - Undefined: no counter logic; ST_BUS waits indefinitely; rsp_err_o only from wb_err_i.
// TESTING (slave = block RAM, LATENCY=2, DATA_WIDTH=32, unless noted)
// - Reset: hold rst_ni=0 3 cycles -> cyc/stb=0, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0.
// - Write 0xDEADBEEF to 0x10, be=0xF, then read 0x10 -> rsp_rdata_o=0xDEADBEEF, err=0;
//   cyc high exactly 2 cycles per transfer, rsp_valid 1 cycle after ack.
// - Write 0x000000AA to 0x10 be=0x1 over 0xDEADBEEF, read 0x10 -> 0xDEADBEAA; wb_sel_o=0x1 seen.
// - Backpressure: rsp_ready_i=0 for 5 cycles -> rsp_valid/rdata stable, req_ready_o=0, no new cyc.
// - Error: model slave asserts wb_err_i with ack same cycle -> rsp_err_o=1, rsp_rdata_o=0.
// - TIMEOUT_EN, TIMEOUT_CYCLES=8, silent slave -> cyc high 8 cycles, rsp_err_o=1; reset during
//   ST_BUS (without macro) -> cyc=0 after next edge, no rsp_valid.

Source files
------------

// File: rtl/wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_bridge
// Brief    : Converts a core-side valid/ready request/response port into
//            single Wishbone classic cycles, one transfer outstanding.
//            Optional bus-wait timeout enabled by defining WB_BRIDGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_bridge #(
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int c_sel_w = DATA_WIDTH / 8;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_bus  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    if (((DATA_WIDTH % 8) != 0) || (TIMEOUT_CYCLES < 2)) begin : g_param_check
        $error("wb_master_bridge: illegal DATA_WIDTH or TIMEOUT_CYCLES");
    end

    logic [1:0]            r_state;
    logic                  r_cyc;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [c_sel_w-1:0]    r_sel;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_timeout;
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= c_st_idle;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_sel   <= '0;
            r_dat   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (req_valid_i) begin
                        r_adr   <= req_addr_i;
                        r_we    <= req_we_i;
                        r_sel   <= req_be_i;
                        r_dat   <= req_wdata_i;
                        r_cyc   <= 1'b1;
                        r_state <= c_st_bus;
`ifdef WB_BRIDGE_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                c_st_bus: begin
                    // err takes priority over a simultaneous ack
                    if (wb_err_i) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_state <= c_st_resp;
                    end else if (wb_ack_i) begin
                        r_rdata <= r_we ? '0 : wb_dat_i;
                        r_err   <= 1'b0;
                        r_cyc   <= 1'b0;
                        r_state <= c_st_resp;
                    end
`ifdef WB_BRIDGE_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                c_st_resp: begin
                    if (rsp_ready_i) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cyc   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == c_st_idle);
    assign rsp_valid_o = (r_state == c_st_resp);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_sel_o    = r_sel;
    assign wb_dat_o    = r_dat;

endmodule
`default_nettype wire
